am_demod_sequencer: RTL and testbench
=====================================

# am_demod_sequencer

Sequencing controller for the AM demodulator magnitude path, clocked by the fast system clock `clk`. It detects each rising edge of the slow sample strobe `clkData`, captures the I/Q pair, and time-shares one 8x8 signed multiplier to form I² + Q². It then runs an 8-step bit-serial integer square root and presents the envelope magnitude on `d_out` with a one-cycle valid pulse. Samples that arrive while a computation is in flight are dropped and flagged.

## Interface
Parameters:
- `OUT_SHIFT`, default 7: left shift applied to the 8-bit root before it drives `d_out`. Legal range 0..8.

Ports:
- `clk`  in  1  system clock; the only clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clkData`  in  1  sample strobe, treated as a level sampled on `clk`. Its rising edge marks a new I/Q pair.
- `I_in`  in  8  in-phase sample, two's complement.
- `Q_in`  in  8  quadrature sample, two's complement.
- `d_out`  out  16  unsigned magnitude: floor(sqrt(I² + Q²)) << OUT_SHIFT.
- `d_valid`  out  1  one-cycle pulse; `d_out` was updated at the same edge.
- `busy`  out  1  high whenever the state is not IDLE.
- `overrun`  out  1  one-cycle pulse when a sample edge is dropped.

## Operation
- Edge detect: register `clkData_q`. A sample edge is the condition `clkData & ~clkData_q`.
- FSM states and transitions:
  - IDLE: on a sample edge, capture `I_in` and `Q_in`, go to SQI.
  - SQI: `acc <= I*I` (unsigned 15-bit). Go to SQQ.
  - SQQ: `rad <= acc + Q*Q` (unsigned 16-bit, maximum 32768). Clear `root` and `rem`. Go to SQRT with `iter` = 7.
  - SQRT: one restoring-sqrt step per clock, consuming two radicand bits MSB-first and producing root bit `iter`. When `iter` = 0, go to DONE.
  - DONE: load `d_out <= {8'b0, root} << OUT_SHIFT` and pulse `d_valid`. Go to IDLE.
- Multiplier sharing: a single signed 8x8 multiplier is used. Its operand mux selects I in SQI and Q in SQQ. No second multiplier is permitted.
- Arithmetic: squares are exact. The root is floor(sqrt(rad)) and is never rounded up. The maximum root is 181 (rad = 32768).
- Overrun: a sample edge seen in any state other than IDLE does not alter the computation. It produces a one-cycle `overrun` pulse and the sample is discarded.
- `d_out` holds its last value between results.

## Timing
- Reset values: `d_out` = 0, `d_valid` = 0, `busy` = 0, `overrun` = 0, state = IDLE, `clkData_q` = 1.
  - `clkData_q` resets to 1 so that `clkData` already high at reset release creates no spurious edge.
- Reset asserted mid-computation aborts it. No `d_valid` is produced for the aborted sample, and `d_out` returns to 0.
- Edge numbering, with edge 0 being the edge where the sample edge is seen in IDLE:
  - Edge 0: I and Q captured; `busy` rises.
  - Edge 1: SQI.
  - Edge 2: SQQ.
  - Edges 3..10: the eight SQRT iterations.
  - Edge 11: DONE; `d_out` loaded and `d_valid` high.
  - `d_valid` is observed high between edge 11 and edge 12, and `busy` falls after edge 11.
- Latency: 11 `clk` cycles from edge detection to valid output.
- The earliest next sample edge that can be accepted is at edge 12. `clkData` period must be at least 12 `clk` cycles.
- A sample edge coinciding with DONE (edge 11) counts as an overrun.
- `I_in` and `Q_in` need to be stable only at edge 0.

## Test plan
- Reset, then hold `clkData` low for 5 cycles -> all outputs stay 0 and no `d_valid`.
- I = 10, Q = 20, single `clkData` rise -> exactly 11 cycles later `d_valid` pulses once with `d_out` = 2816 (root 22). `busy` is high for 11 cycles.
- I = -128, Q = -128 -> `d_out` = 23168 (root 181). Then I = 127, Q = -128 -> `d_out` = 23040 (root 180). Then I = 0, Q = 0 -> `d_out` = 0.
- I = 3, Q = 4, with a second `clkData` rise 6 cycles after the first -> one `overrun` pulse. The second sample is ignored and `d_out` = 640.
  - Repeat with the second rise exactly 12 cycles after the first -> no overrun, and two `d_valid` pulses.
- `clkData` held high through reset release -> no computation starts. The next genuine low-to-high transition is processed normally.
- Assert `reset` at edge 5 of a computation -> no `d_valid`, and all outputs are 0. A subsequent sample (I = 10, Q = 20) still yields 2816.

Source files
------------

// File: rtl/am_demod_sequencer.sv
// rtl/am_demod_sequencer.sv - AM demodulator magnitude sequencer: shared-multiplier I^2+Q^2 and bit-serial sqrt
module am_demod_sequencer #(
    parameter int OUT_SHIFT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkData,
    input  logic [7:0]  I_in,
    input  logic [7:0]  Q_in,
    output logic [15:0] d_out,
    output logic        d_valid,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, SQI, SQQ, SQRT, DONE} state_t;

    state_t      state_q, state_d;
    logic        clkData_q;
    logic [7:0]  i_q, i_d, q_q, q_d;
    logic [14:0] acc_q, acc_d;
    logic [15:0] rad_q, rad_d;
    logic [7:0]  root_q, root_d;
    logic [9:0]  rem_q, rem_d;
    logic [2:0]  iter_q, iter_d;
    logic [15:0] d_out_q, d_out_d;
    logic        d_valid_q, d_valid_d;
    logic        overrun_q, overrun_d;

    logic        sample_edge;
    logic [7:0]  mul_a;
    logic [15:0] mul_ext;
    logic [15:0] prod;
    logic [11:0] rem_sh;
    logic [11:0] trial;
    logic        trial_fits;
    logic [11:0] rem_diff;
    logic        unused_rem_hi;

    assign sample_edge = clkData & ~clkData_q;

    // Single shared multiplier; the operand mux picks I while squaring I, Q otherwise
    assign mul_a   = (state_q == SQI) ? i_q : q_q;
    assign mul_ext = {{8{mul_a[7]}}, mul_a};
    assign prod    = $unsigned($signed(mul_ext) * $signed(mul_ext));

    // Restoring sqrt step: bring down two radicand bits, try subtracting (4*root + 1)
    assign rem_sh     = {rem_q, rad_q[15:14]};
    assign trial      = {2'b00, root_q, 2'b01};
    assign trial_fits = (rem_sh >= trial);
    assign rem_diff   = trial_fits ? (rem_sh - trial) : rem_sh;
    // Remainder never exceeds 2*root, so the top two bits are always zero
    assign unused_rem_hi = ^rem_diff[11:10];

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        q_d       = q_q;
        acc_d     = acc_q;
        rad_d     = rad_q;
        root_d    = root_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        d_out_d   = d_out_q;
        d_valid_d = 1'b0;
        overrun_d = sample_edge && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sample_edge) begin
                    i_d     = I_in;
                    q_d     = Q_in;
                    state_d = SQI;
                end
            end
            SQI: begin
                acc_d   = prod[14:0];
                state_d = SQQ;
            end
            SQQ: begin
                rad_d   = {1'b0, acc_q} + prod;
                root_d  = 8'd0;
                rem_d   = 10'd0;
                iter_d  = 3'd7;
                state_d = SQRT;
            end
            SQRT: begin
                rad_d  = {rad_q[13:0], 2'b00};
                root_d = {root_q[6:0], trial_fits};
                rem_d  = rem_diff[9:0];
                iter_d = iter_q - 3'd1;
                if (iter_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                d_out_d   = {8'b0, root_q} << OUT_SHIFT;
                d_valid_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; clkData_q resets high so a strobe already high is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clkData_q <= 1'b1;
            i_q       <= 8'd0;
            q_q       <= 8'd0;
            acc_q     <= 15'd0;
            rad_q     <= 16'd0;
            root_q    <= 8'd0;
            rem_q     <= 10'd0;
            iter_q    <= 3'd0;
            d_out_q   <= 16'd0;
            d_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clkData_q <= clkData;
            i_q       <= i_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            rad_q     <= rad_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            iter_q    <= iter_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_am_demod_sequencer.sv
// tb/tb_am_demod_sequencer.sv - directed vector bench for am_demod_sequencer
module tb_am_demod_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clkData;
    logic [7:0]  I_in;
    logic [7:0]  Q_in;
    logic [15:0] d_out;
    logic        d_valid;
    logic        busy;
    logic        overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] i;
        logic [7:0] q;
        int         exp;
    } vec_t;

    vec_t vecs[9];

    am_demod_sequencer #(.OUT_SHIFT(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .clkData (clkData),
        .I_in    (I_in),
        .Q_in    (Q_in),
        .d_out   (d_out),
        .d_valid (d_valid),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sample(input logic [7:0] i, input logic [7:0] q, input int exp, input string name);
        int cyc;
        int busy_cnt;
        I_in    = i;
        Q_in    = q;
        clkData = 1'b1;
        tick();
        clkData  = 1'b0;
        I_in     = ~i;
        Q_in     = ~q;
        cyc      = 0;
        busy_cnt = 0;
        while (!d_valid && cyc < 20) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, 11);
        check({name, " d_out"}, int'(d_out), exp);
        check({name, " busy cycles"}, busy_cnt, 11);
        check({name, " busy low at valid"}, int'(busy), 0);
        tick();
        check({name, " valid single pulse"}, int'(d_valid), 0);
        check({name, " d_out held"}, int'(d_out), exp);
    endtask

    task automatic run_window(input int gap, input logic [7:0] i, input logic [7:0] q,
                              output int nv, output int nov, output int last_out);
        nv       = 0;
        nov      = 0;
        last_out = -1;
        for (int c = 0; c < 30; c++) begin
            clkData = (c == 0 || c == gap);
            I_in    = i;
            Q_in    = q;
            tick();
            if (d_valid) begin
                nv++;
                last_out = int'(d_out);
            end
            if (overrun) nov++;
        end
        clkData = 1'b0;
    endtask

    initial begin
        int nv, nov, lo, nb;

        vecs[0] = '{8'd10,  8'd20,  2816};
        vecs[1] = '{8'h80,  8'h80,  23168};
        vecs[2] = '{8'd127, 8'h80,  23040};
        vecs[3] = '{8'd0,   8'd0,   0};
        vecs[4] = '{8'd3,   8'd4,   640};
        vecs[5] = '{8'hFF,  8'd0,   128};
        vecs[6] = '{8'd15,  8'd15,  2688};
        vecs[7] = '{8'hF9,  8'd24,  3200};
        vecs[8] = '{8'd1,   8'd1,   128};

        reset   = 1'b1;
        clkData = 1'b0;
        I_in    = 8'd0;
        Q_in    = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("reset idle outputs", int'({d_out, d_valid, busy, overrun}), 0);
        end

        for (int k = 0; k < 9; k++) begin
            run_sample(vecs[k].i, vecs[k].q, vecs[k].exp, $sformatf("vec%0d", k));
            tick();
        end

        run_window(6, 8'd3, 8'd4, nv, nov, lo);
        check("gap6 overrun pulses", nov, 1);
        check("gap6 valid pulses", nv, 1);
        check("gap6 d_out", lo, 640);

        run_window(11, 8'd3, 8'd4, nv, nov, lo);
        check("gap11 overrun pulses", nov, 1);
        check("gap11 valid pulses", nv, 1);

        run_window(12, 8'd3, 8'd4, nv, nov, lo);
        check("gap12 overrun pulses", nov, 0);
        check("gap12 valid pulses", nv, 2);
        check("gap12 d_out", lo, 640);

        I_in    = 8'd10;
        Q_in    = 8'd20;
        clkData = 1'b1;
        tick();
        clkData = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("abort d_valid", int'(d_valid), 0);
        check("abort d_out", int'(d_out), 0);
        check("abort busy", int'(busy), 0);
        check("abort overrun", int'(overrun), 0);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (d_valid) nv++;
        end
        check("abort no later valid", nv, 0);
        run_sample(8'd10, 8'd20, 2816, "after abort");

        reset   = 1'b1;
        clkData = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        nv = 0;
        nb = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (d_valid) nv++;
            if (busy) nb++;
        end
        check("high at release no valid", nv, 0);
        check("high at release no busy", nb, 0);
        clkData = 1'b0;
        tick();
        run_sample(8'd3, 8'd4, 640, "after high release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
